// File: rtl/sdram_port_bridge_pkg.sv
// Shared types and constants for the SDRAM port bridge: FSM encoding, word-address width,
// default timeout and error data.
package sdram_port_bridge_pkg;

  localparam int unsigned WORD_AW      = 24;
  localparam int unsigned DEF_TIMEOUT  = 255;
  localparam logic [15:0] DEF_ERR_DATA = 16'hDEAD;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd0  = 3'd1,
    StRd1  = 3'd2,
    StWr   = 3'd3,
    StDone = 3'd4
  } state_e;

  // Byte lane for a single-byte write; bit 1 is the high byte.
  function automatic logic [1:0] byte_en(input logic addr_lsb);
    return addr_lsb ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_phase_timer.sv
// Per-phase watchdog: cleared on load, counts enabled cycles, flags the TIMEOUT-th cycle.
module sdram_phase_timer
  import sdram_port_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;
  logic [7:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_load) begin
      w_cnt_d = 8'd0;
    end else if (i_en && (r_cnt != 8'hFF)) begin
      w_cnt_d = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/sdram_port_bridge.sv
// Byte-wide requester to 16-bit SDRAM controller bridge: one or two word phases per request,
// byte-lane write masking and a per-phase timeout that substitutes error data.
module sdram_port_bridge
  import sdram_port_bridge_pkg::*;
#(
  parameter bit          LONG_READ = 1'b1,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter logic [15:0] ERR_DATA  = DEF_ERR_DATA
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [24:0]          sdram_addr,
  input  logic [7:0]           sdram_din,
  input  logic                 sdram_req,
  input  logic                 sdram_rnw,
  output logic                 sdram_ready,
  output logic [15:0]          sdram_dout,
  output logic [31:0]          sdram_ldout,
  output logic [WORD_AW-1:0]   ctl_addr,
  output logic                 ctl_we,
  output logic [15:0]          ctl_wdata,
  output logic [1:0]           ctl_be,
  output logic                 ctl_req,
  input  logic                 ctl_ack,
  input  logic                 ctl_rvalid,
  input  logic [15:0]          ctl_rdata,
  output logic [7:0]           err_cnt
);

  state_e             r_state, w_state_d;
  logic               r_ready, w_ready_d;
  logic [15:0]        r_dout, w_dout_d;
  logic [31:0]        r_ldout, w_ldout_d;
  logic               r_req, w_req_d;
  logic               r_we, w_we_d;
  logic [WORD_AW-1:0] r_addr, w_addr_d;
  logic [15:0]        r_wdata, w_wdata_d;
  logic [1:0]         r_be, w_be_d;
  logic [7:0]         r_err_cnt, w_err_cnt_d;
  logic               r_armed, w_armed_d;

  logic        w_load;
  logic        w_en;
  logic        w_expire;
  logic [15:0] w_rdata;
  logic [7:0]  w_err_inc;

  assign w_en      = (r_state == StRd0) || (r_state == StRd1) || (r_state == StWr);
  assign w_err_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

  sdram_phase_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk    (CLK),
    .i_rst_n  (RESET_N),
    .i_load   (w_load),
    .i_en     (w_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_d   = r_state;
    w_ready_d   = r_ready;
    w_dout_d    = r_dout;
    w_ldout_d   = r_ldout;
    w_req_d     = r_req;
    w_we_d      = r_we;
    w_addr_d    = r_addr;
    w_wdata_d   = r_wdata;
    w_be_d      = r_be;
    w_err_cnt_d = r_err_cnt;
    w_armed_d   = r_armed;
    w_load      = 1'b0;
    w_rdata     = ctl_rvalid ? ctl_rdata : ERR_DATA;

    if (!sdram_req) begin
      w_armed_d = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (sdram_req && r_armed) begin
          w_armed_d = 1'b0;
          w_ready_d = 1'b0;
          w_req_d   = 1'b1;
          w_addr_d  = sdram_addr[24:1];
          w_load    = 1'b1;
          if (sdram_rnw) begin
            w_we_d    = 1'b0;
            w_state_d = StRd0;
          end else begin
            w_we_d    = 1'b1;
            w_wdata_d = {sdram_din, sdram_din};
            w_be_d    = byte_en(sdram_addr[0]);
            w_state_d = StWr;
          end
        end
      end
      StRd0, StRd1: begin
        if (ctl_ack) begin
          w_req_d = 1'b0;
        end
        // rvalid doubles as an implicit ack; a timeout completes the phase with error data
        if (ctl_rvalid || w_expire) begin
          w_req_d = 1'b0;
          if (!ctl_rvalid) begin
            w_err_cnt_d = w_err_inc;
          end
          if (r_state == StRd0) begin
            w_dout_d        = w_rdata;
            w_ldout_d[15:0] = w_rdata;
            if (LONG_READ) begin
              w_addr_d  = r_addr + 24'd1;
              w_req_d   = 1'b1;
              w_load    = 1'b1;
              w_state_d = StRd1;
            end else begin
              w_state_d = StDone;
            end
          end else begin
            w_ldout_d[31:16] = w_rdata;
            w_state_d        = StDone;
          end
        end
      end
      StWr: begin
        if (ctl_ack || w_expire) begin
          w_req_d   = 1'b0;
          w_we_d    = 1'b0;
          w_state_d = StDone;
          if (!ctl_ack) begin
            w_err_cnt_d = w_err_inc;
          end
        end
      end
      StDone: begin
        w_ready_d = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= StIdle;
      r_ready   <= 1'b1;
      r_dout    <= 16'd0;
      r_ldout   <= 32'd0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 16'd0;
      r_be      <= 2'b00;
      r_err_cnt <= 8'd0;
      r_armed   <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_ready   <= w_ready_d;
      r_dout    <= w_dout_d;
      r_ldout   <= w_ldout_d;
      r_req     <= w_req_d;
      r_we      <= w_we_d;
      r_addr    <= w_addr_d;
      r_wdata   <= w_wdata_d;
      r_be      <= w_be_d;
      r_err_cnt <= w_err_cnt_d;
      r_armed   <= w_armed_d;
    end
  end

  assign sdram_ready = r_ready;
  assign sdram_dout  = r_dout;
  assign sdram_ldout = r_ldout;
  assign ctl_addr    = r_addr;
  assign ctl_we      = r_we;
  assign ctl_wdata   = r_wdata;
  assign ctl_be      = r_be;
  assign ctl_req     = r_req;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_sdram_port_bridge.sv
// Directed bench for sdram_port_bridge with a negedge-driven controller model that logs requests.
module tb_sdram_port_bridge;

  logic        CLK;
  logic        RESET_N;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic        sdram_req;
  logic        sdram_rnw;
  logic        sdram_ready;
  logic [15:0] sdram_dout;
  logic [31:0] sdram_ldout;
  logic [23:0] ctl_addr;
  logic        ctl_we;
  logic [15:0] ctl_wdata;
  logic [1:0]  ctl_be;
  logic        ctl_req;
  logic        ctl_ack;
  logic        ctl_rvalid;
  logic [15:0] ctl_rdata;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  sdram_port_bridge #(
    .LONG_READ (1'b1),
    .TIMEOUT   (4),
    .ERR_DATA  (16'hDEAD)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .sdram_addr  (sdram_addr),
    .sdram_din   (sdram_din),
    .sdram_req   (sdram_req),
    .sdram_rnw   (sdram_rnw),
    .sdram_ready (sdram_ready),
    .sdram_dout  (sdram_dout),
    .sdram_ldout (sdram_ldout),
    .ctl_addr    (ctl_addr),
    .ctl_we      (ctl_we),
    .ctl_wdata   (ctl_wdata),
    .ctl_be      (ctl_be),
    .ctl_req     (ctl_req),
    .ctl_ack     (ctl_ack),
    .ctl_rvalid  (ctl_rvalid),
    .ctl_rdata   (ctl_rdata),
    .err_cnt     (err_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem(input logic [23:0] a);
    case (a)
      24'd2:   return 16'h1234;
      24'd3:   return 16'h5678;
      default: return a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  // Controller model: split = ack then rvalid a cycle later; mute_en suppresses rvalid for one
  // word address; silent suppresses all responses.
  bit          split   = 1'b0;
  bit          silent  = 1'b0;
  bit          mute_en = 1'b0;
  logic [23:0] mute_addr = '0;
  bit          pend_rv = 1'b0;
  logic [23:0] pend_addr;
  int          n_req = 0;
  logic [23:0] addr_log  [64];
  logic        we_log    [64];
  logic [15:0] wdata_log [64];
  logic [1:0]  be_log    [64];

  always @(negedge CLK) begin
    ctl_ack    = 1'b0;
    ctl_rvalid = 1'b0;
    if (!RESET_N) begin
      pend_rv = 1'b0;
    end else if (pend_rv) begin
      ctl_rvalid = 1'b1;
      ctl_rdata  = mem(pend_addr);
      pend_rv    = 1'b0;
    end else if (ctl_req && !silent) begin
      if (n_req < 64) begin
        addr_log[n_req]  = ctl_addr;
        we_log[n_req]    = ctl_we;
        wdata_log[n_req] = ctl_wdata;
        be_log[n_req]    = ctl_be;
      end
      n_req++;
      ctl_ack = 1'b1;
      if (!ctl_we && !(mute_en && ctl_addr == mute_addr)) begin
        if (split) begin
          pend_rv   = 1'b1;
          pend_addr = ctl_addr;
        end else begin
          ctl_rvalid = 1'b1;
          ctl_rdata  = mem(ctl_addr);
        end
      end
    end
  end

  // Issue one request; busy = negedges from the first one seeing ready low to ready high.
  task automatic run_req(input logic [24:0] a, input logic [7:0] d, input logic rnw,
                         input bit hold, output int busy);
    int k;
    busy = 0;
    @(negedge CLK);
    sdram_addr = a;
    sdram_din  = d;
    sdram_rnw  = rnw;
    sdram_req  = 1'b1;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (sdram_ready && k < 10);
    if (sdram_ready) begin
      check("ready_drop_timeout", {31'd0, sdram_ready}, 32'd0);
      sdram_req = 1'b0;
      return;
    end
    if (!hold) sdram_req = 1'b0;
    do begin
      @(negedge CLK);
      busy++;
    end while (!sdram_ready && busy < 50);
    if (!sdram_ready) check("ready_rise_timeout", {31'd0, sdram_ready}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int base;
    int k;
    RESET_N    = 1'b0;
    sdram_addr = '0;
    sdram_din  = '0;
    sdram_req  = 1'b0;
    sdram_rnw  = 1'b0;
    ctl_ack    = 1'b0;
    ctl_rvalid = 1'b0;
    ctl_rdata  = '0;
    repeat (2) @(negedge CLK);
    check("rst_ready", {31'd0, sdram_ready}, 32'd1);
    check("rst_dout", {16'd0, sdram_dout}, 32'd0);
    check("rst_ldout", sdram_ldout, 32'd0);
    check("rst_ctl", {ctl_req, ctl_we, ctl_be, 4'd0, ctl_addr}, 32'd0);
    check("rst_err", {24'd0, err_cnt}, 32'd0);
    RESET_N = 1'b1;

    // Long read of words 2,3
    base = n_req;
    run_req(25'h000004, 8'h00, 1'b1, 1'b0, busy);
    check("rd_nreq", n_req - base, 2);
    check("rd_addr0", {8'd0, addr_log[base]}, 32'd2);
    check("rd_addr1", {8'd0, addr_log[base+1]}, 32'd3);
    check("rd_dout", {16'd0, sdram_dout}, 32'h1234);
    check("rd_ldout", sdram_ldout, 32'h56781234);
    check("rd_busy", busy, 3);

    // Odd-byte write
    base = n_req;
    run_req(25'h000003, 8'hA5, 1'b0, 1'b0, busy);
    check("wr_addr", {8'd0, addr_log[base]}, 32'd1);
    check("wr_we", {31'd0, we_log[base]}, 32'd1);
    check("wr_wdata", {16'd0, wdata_log[base]}, 32'hA5A5);
    check("wr_be", {30'd0, be_log[base]}, 32'd2);
    check("wr_busy", busy, 2);
    check("wr_idle_ctl", {30'd0, ctl_req, ctl_we}, 32'd0);
    check("wr_dout_hold", {16'd0, sdram_dout}, 32'h1234);
    check("wr_ldout_hold", sdram_ldout, 32'h56781234);

    // Even-byte write
    base = n_req;
    run_req(25'h000004, 8'h3C, 1'b0, 1'b0, busy);
    check("wr2_addr", {8'd0, addr_log[base]}, 32'd2);
    check("wr2_wdata_be", {14'd0, be_log[base], wdata_log[base]}, {14'd0, 2'b01, 16'h3C3C});

    // Word address wrap on the second phase
    base = n_req;
    run_req(25'h1FFFFFF, 8'h00, 1'b1, 1'b0, busy);
    check("wrap_addr0", {8'd0, addr_log[base]}, 32'h00FFFFFF);
    check("wrap_addr1", {8'd0, addr_log[base+1]}, 32'd0);
    check("wrap_ldout", sdram_ldout, 32'h5A5AA5A5);
    check("wrap_dout", {16'd0, sdram_dout}, 32'hA5A5);

    // Ack and rvalid on separate cycles
    split = 1'b1;
    run_req(25'h000010, 8'h00, 1'b1, 1'b0, busy);
    split = 1'b0;
    check("split_ldout", sdram_ldout, 32'h5A535A52);
    check("split_busy", busy, 5);

    // Phase-2 rvalid never arrives
    mute_en   = 1'b1;
    mute_addr = 24'h000021;
    run_req(25'h000040, 8'h00, 1'b1, 1'b0, busy);
    mute_en = 1'b0;
    check("to_ldout", sdram_ldout, 32'hDEAD5A7A);
    check("to_dout", {16'd0, sdram_dout}, 32'h5A7A);
    check("to_err", {24'd0, err_cnt}, 32'd1);
    check("to_req", {31'd0, ctl_req}, 32'd0);
    check("to_busy", busy, 6);

    // Request held high through completion must not retrigger
    base = n_req;
    run_req(25'h000006, 8'h11, 1'b0, 1'b1, busy);
    repeat (5) @(negedge CLK);
    check("hold_once", n_req - base, 1);
    check("hold_ready", {31'd0, sdram_ready}, 32'd1);
    sdram_req = 1'b0;
    @(negedge CLK);
    sdram_req = 1'b1;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (sdram_ready && k < 10);
    check("rearm_accept", {31'd0, sdram_ready}, 32'd0);
    sdram_req = 1'b0;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!sdram_ready && k < 20);
    check("rearm_count", n_req - base, 2);

    // Asynchronous reset during RD0
    silent = 1'b1;
    @(negedge CLK);
    sdram_addr = 25'h000008;
    sdram_rnw  = 1'b1;
    sdram_req  = 1'b1;
    @(negedge CLK);
    check("mid_req", {30'd0, sdram_ready, ctl_req}, 32'd1);
    @(negedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, sdram_ready}, 32'd1);
    check("mid_rst_ctl", {ctl_req, ctl_we, ctl_be, 4'd0, ctl_addr}, 32'd0);
    check("mid_rst_wdata", {16'd0, ctl_wdata}, 32'd0);
    check("mid_rst_data", sdram_ldout | {16'd0, sdram_dout}, 32'd0);
    check("mid_rst_err", {24'd0, err_cnt}, 32'd0);
    sdram_req = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    silent  = 1'b0;
    run_req(25'h000004, 8'h00, 1'b1, 1'b0, busy);
    check("post_rst_ldout", sdram_ldout, 32'h56781234);
    check("post_rst_busy", busy, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_bridge.md
Name: sdram_port_bridge

Overview:
Downstream neighbour of the SDRAM test/requester stage. Takes its byte-wide request handshake (addr/din/req/rnw) and returns ready, a 16-bit dout and a 32-bit ldout. Converts each request into one or two word transactions on the 16-bit SDRAM controller port (req/ack/rvalid), with byte-lane masking for writes and a per-transaction timeout.

Parameters:
LONG_READ, 1, 1 = every read fetches two consecutive words to build ldout; 0 = one word only, ldout[31:16] holds its previous value.
TIMEOUT, 255, max cycles waited for ctl_ack or ctl_rvalid before forced completion (8-bit counter; legal range 1..255).
ERR_DATA, 16'hDEAD, word substituted for the read data when a phase times out.

Ports:
CLK  in  1  clock (all logic on rising edge).
RESET_N  in  1  asynchronous active-low reset.
sdram_addr  in  25  byte address from requester.
sdram_din  in  8  write byte.
sdram_req  in  1  request level; held until ready drops.
sdram_rnw  in  1  1 = read, 0 = write.
sdram_ready  out  1  1 = idle/complete, 0 = busy.
sdram_dout  out  16  word containing the addressed byte.
sdram_ldout  out  32  {word at addr+2 (byte address), word at addr}.
ctl_addr  out  24  controller word address.
ctl_we  out  1  controller write enable.
ctl_wdata  out  16  controller write data.
ctl_be  out  2  byte enables ([1] = high byte).
ctl_req  out  1  controller request; held until ctl_ack.
ctl_ack  in  1  one-cycle pulse: request accepted.
ctl_rvalid  in  1  one-cycle pulse: ctl_rdata valid.
ctl_rdata  in  16  read data.
err_cnt  out  8  timeout counter; saturates at 255.

Behaviour:
- Reset: sdram_ready=1, sdram_dout=0, sdram_ldout=0, ctl_req=0, ctl_we=0, ctl_addr=0, ctl_wdata=0, ctl_be=0, err_cnt=0, armed=1, state IDLE.
- Armed flag: cleared on accept, set whenever sdram_req is sampled 0. Accept requires armed=1, so a request held high across completion does not retrigger.
- States: IDLE, RD0, RD1, WR, DONE.
- IDLE: if sdram_req && armed, latch addr/din/rnw, set ready=0 next cycle and assert ctl_req. Word address = addr[24:1].
  - Read: ctl_we=0, next state RD0.
  - Write: ctl_we=1, ctl_wdata={din,din}, ctl_be = addr[0] ? 2'b10 : 2'b01, next state WR.
- RD0: drop ctl_req on ctl_ack. On ctl_rvalid, capture sdram_dout and sdram_ldout[15:0].
  - LONG_READ=1: reissue at word address +1 (wraps 24'hFFFFFF -> 0), go to RD1.
  - LONG_READ=0: go to DONE.
- RD1: same handshake; on ctl_rvalid capture sdram_ldout[31:16], go to DONE.
- WR: drop ctl_req and ctl_we on ctl_ack, go to DONE.
- ack and rvalid in the same cycle: both honoured, so the phase completes that cycle.
- rvalid before ack: treated as implicit ack; ctl_req drops.
- DONE: ready=1 next cycle, then IDLE. Minimum latency from accept to ready high is 3 cycles with ack+rvalid arriving one cycle after the request.
- Timeout: the counter clears at each phase start and counts cycles in RD0/RD1/WR.
  - On reaching TIMEOUT: drop ctl_req, write ERR_DATA into any read capture still pending, increment err_cnt (saturating), and advance as if the phase completed.
  - A late ack or rvalid arriving in IDLE/DONE is ignored.
- Outputs sdram_dout/ldout hold their values until the next read capture; writes do not change them.
- Reset mid-transaction aborts immediately with reset values; the controller must tolerate req dropping without ack.

Decomposition:
- Shared package: state encoding (3-bit enum), word-address width 24, default TIMEOUT and ERR_DATA constants.
- One natural sub-module, sdram_phase_timer: load/count/expire counter with a TIMEOUT parameter, reused per phase.

Test Plan:
- Read at addr 25'h000004, LONG_READ=1; controller returns 16'h1234 for word 2 and 16'h5678 for word 3 -> ctl_addr 2 then 3; dout=16'h1234, ldout=32'h56781234; ready low for 3+ cycles, then high.
- Write din=8'hA5 at addr 25'h000003 -> ctl_addr=1, ctl_wdata=16'hA5A5, ctl_be=2'b10, ctl_we=1 until ack; ready returns high; dout unchanged.
- Read at word address 24'hFFFFFF -> second phase ctl_addr=0 (wrap).
- Controller never sends rvalid on phase 2, TIMEOUT=4 -> after 4 cycles ctl_req=0, ldout[31:16]=16'hDEAD, err_cnt=1, ready=1.
- sdram_req held high through completion -> exactly one transaction; a second starts only after req has been sampled low then high again.
- RESET_N pulsed low during RD0 -> all outputs return to reset values asynchronously; the next read after reset completes normally.
